// File: rtl/cpu_sequencer.sv
// Instruction sequencer for the 4-bit CPU: fetches from program ROM, decodes,
// drives register-file load strobes and write data, and owns the PC and carry flag.
module cpu_sequencer #(
   parameter logic [3:0] PC_RESET = 4'd0
) (
   input  logic       clk_cpu,
   input  logic       reset,
   input  logic       run,
   input  logic       step,
   output logic [3:0] rom_addr,
   input  logic [7:0] rom_data,
   input  logic [3:0] reg_a,
   input  logic [3:0] reg_b,
   input  logic [3:0] in_port,
   output logic       load_a,
   output logic       load_b,
   output logic       load_out,
   output logic [3:0] dat_wr,
   output logic       carry,
   output logic [1:0] state
);

   localparam int unsigned DW = 4;

   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;

   localparam logic [3:0] OP_ADD_A  = 4'b0000;
   localparam logic [3:0] OP_MOV_AB = 4'b0001;
   localparam logic [3:0] OP_IN_A   = 4'b0010;
   localparam logic [3:0] OP_MOV_AI = 4'b0011;
   localparam logic [3:0] OP_MOV_BA = 4'b0100;
   localparam logic [3:0] OP_ADD_B  = 4'b0101;
   localparam logic [3:0] OP_IN_B   = 4'b0110;
   localparam logic [3:0] OP_MOV_BI = 4'b0111;
   localparam logic [3:0] OP_OUT_B  = 4'b1001;
   localparam logic [3:0] OP_OUT_I  = 4'b1011;
   localparam logic [3:0] OP_JNC    = 4'b1110;
   localparam logic [3:0] OP_JMP    = 4'b1111;

   logic [1:0]    state_nxt;
   logic [DW-1:0] pc, pc_nxt;
   logic [7:0]    ir, ir_nxt;
   logic          carry_nxt;
   logic [DW-1:0] dat_wr_nxt;
   logic          load_a_nxt, load_b_nxt, load_out_nxt;
   // next PC and carry are resolved in DECODE and committed at the end of EXEC
   logic [DW-1:0] npc_q, npc_nxt;
   logic          ncarry_q, ncarry_nxt;

   logic [DW-1:0] opcode, imm, pc_inc;
   logic [DW:0]   sum_a, sum_b;

   assign opcode   = ir[7:4];
   assign imm      = ir[3:0];
   assign pc_inc   = pc + DW'(1);
   assign sum_a    = {1'b0, reg_a} + {1'b0, imm};
   assign sum_b    = {1'b0, reg_b} + {1'b0, imm};
   assign rom_addr = pc;

   // state and registered outputs
   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         state    <= ST_FETCH;
         pc       <= PC_RESET;
         ir       <= 8'h00;
         carry    <= 1'b0;
         dat_wr   <= '0;
         load_a   <= 1'b0;
         load_b   <= 1'b0;
         load_out <= 1'b0;
         npc_q    <= PC_RESET;
         ncarry_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         ir       <= ir_nxt;
         carry    <= carry_nxt;
         dat_wr   <= dat_wr_nxt;
         load_a   <= load_a_nxt;
         load_b   <= load_b_nxt;
         load_out <= load_out_nxt;
         npc_q    <= npc_nxt;
         ncarry_q <= ncarry_nxt;
      end
   end

   // next-state, decode and commit logic
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      ir_nxt       = ir;
      carry_nxt    = carry;
      dat_wr_nxt   = dat_wr;
      load_a_nxt   = 1'b0;
      load_b_nxt   = 1'b0;
      load_out_nxt = 1'b0;
      npc_nxt      = npc_q;
      ncarry_nxt   = ncarry_q;

      case (state)
         ST_FETCH: begin
            if (run || step) begin
               ir_nxt    = rom_data;
               state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_nxt  = ST_EXEC;
            npc_nxt    = pc_inc;
            ncarry_nxt = 1'b0;
            dat_wr_nxt = '0;
            case (opcode)
               OP_ADD_A: begin
                  dat_wr_nxt = sum_a[DW-1:0];
                  ncarry_nxt = sum_a[DW];
                  load_a_nxt = 1'b1;
               end
               OP_ADD_B: begin
                  dat_wr_nxt = sum_b[DW-1:0];
                  ncarry_nxt = sum_b[DW];
                  load_b_nxt = 1'b1;
               end
               OP_MOV_AI: begin
                  dat_wr_nxt = imm;
                  load_a_nxt = 1'b1;
               end
               OP_MOV_BI: begin
                  dat_wr_nxt = imm;
                  load_b_nxt = 1'b1;
               end
               OP_MOV_AB: begin
                  dat_wr_nxt = reg_b;
                  load_a_nxt = 1'b1;
               end
               OP_MOV_BA: begin
                  dat_wr_nxt = reg_a;
                  load_b_nxt = 1'b1;
               end
               OP_IN_A: begin
                  dat_wr_nxt = in_port;
                  load_a_nxt = 1'b1;
               end
               OP_IN_B: begin
                  dat_wr_nxt = in_port;
                  load_b_nxt = 1'b1;
               end
               OP_OUT_B: begin
                  dat_wr_nxt   = reg_b;
                  load_out_nxt = 1'b1;
               end
               OP_OUT_I: begin
                  dat_wr_nxt   = imm;
                  load_out_nxt = 1'b1;
               end
               OP_JMP: npc_nxt = imm;
               // carry here is still the value left by the previous instruction
               OP_JNC: if (!carry) npc_nxt = imm;
               default: ;
            endcase
         end
         ST_EXEC: begin
            pc_nxt    = npc_q;
            carry_nxt = ncarry_q;
            state_nxt = ST_FETCH;
         end
         default: state_nxt = ST_FETCH;
      endcase
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed program scenarios plus random programs checked
// against an instruction-level architectural model.
module tb_cpu_sequencer;

   logic       clk_cpu = 1'b0;
   logic       reset   = 1'b1;
   logic       run     = 1'b0;
   logic       step    = 1'b0;
   logic [3:0] in_port = 4'd0;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic [3:0] reg_a, reg_b;
   logic       load_a, load_b, load_out;
   logic [3:0] dat_wr;
   logic       carry;
   logic [1:0] state;

   logic [7:0] rom [16];
   logic [3:0] ra = 4'd0, rb = 4'd0, ro = 4'd0;

   int vecs = 0;
   int errs = 0;

   // architectural model state
   int pc_m, c_m, a_m, b_m, o_m;

   cpu_sequencer #(.PC_RESET(4'd0)) dut (
      .clk_cpu (clk_cpu),
      .reset   (reset),
      .run     (run),
      .step    (step),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .reg_a   (reg_a),
      .reg_b   (reg_b),
      .in_port (in_port),
      .load_a  (load_a),
      .load_b  (load_b),
      .load_out(load_out),
      .dat_wr  (dat_wr),
      .carry   (carry),
      .state   (state)
   );

   always #5 clk_cpu = ~clk_cpu;

   assign rom_data = rom[rom_addr];
   assign reg_a    = ra;
   assign reg_b    = rb;

   // register files A, B and OUT sharing the CPU reset
   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         ra <= 4'd0;
         rb <= 4'd0;
         ro <= 4'd0;
      end else begin
         if (load_a)   ra <= dat_wr;
         if (load_b)   rb <= dat_wr;
         if (load_out) ro <= dat_wr;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      run   = 1'b0;
      step  = 1'b0;
      repeat (2) @(negedge clk_cpu);
      reset = 1'b0;
      pc_m = 0; c_m = 0; a_m = 0; b_m = 0; o_m = 0;
   endtask

   // Executes one instruction starting in FETCH at a negedge; returns at the next FETCH.
   task automatic exec_one(input bit use_step);
      logic [7:0] ins;
      logic [2:0] exp_ld;
      int op, im, npc, nc, d, s;
      ins = rom[4'(pc_m)];
      op  = int'(ins[7:4]);
      im  = int'(ins[3:0]);
      in_port = 4'($urandom);
      if (use_step) begin run = 1'b0; step = 1'b1; end
      else          begin run = 1'b1; step = 1'b0; end
      npc = (pc_m + 1) % 16; nc = 0; d = 0; exp_ld = 3'b000;
      case (op)
         0:  begin s = a_m + im; d = s % 16; nc = (s > 15) ? 1 : 0; exp_ld = 3'b100; end
         5:  begin s = b_m + im; d = s % 16; nc = (s > 15) ? 1 : 0; exp_ld = 3'b010; end
         3:  begin d = im;           exp_ld = 3'b100; end
         7:  begin d = im;           exp_ld = 3'b010; end
         1:  begin d = b_m;          exp_ld = 3'b100; end
         4:  begin d = a_m;          exp_ld = 3'b010; end
         2:  begin d = int'(in_port); exp_ld = 3'b100; end
         6:  begin d = int'(in_port); exp_ld = 3'b010; end
         9:  begin d = b_m;          exp_ld = 3'b001; end
         11: begin d = im;           exp_ld = 3'b001; end
         15: npc = im;
         14: if (c_m == 0) npc = im;
         default: ;
      endcase

      vecs++;
      if (state !== 2'd0 || rom_addr !== 4'(pc_m))
         begin errs++; $display("FAIL fetch: state=%0d rom_addr=%0d, required state=0 rom_addr=%0d", state, rom_addr, pc_m); end
      @(negedge clk_cpu);
      if (use_step) step = 1'b0;
      vecs++;
      if (state !== 2'd1 || {load_a, load_b, load_out} !== 3'b000)
         begin errs++; $display("FAIL decode: state=%0d loads=%b, required state=1 loads=000", state, {load_a, load_b, load_out}); end
      @(negedge clk_cpu);
      in_port = 4'($urandom);
      vecs++;
      if (state !== 2'd2 || {load_a, load_b, load_out} !== exp_ld || carry !== 1'(c_m))
         begin errs++; $display("FAIL exec ins=%h: state=%0d loads=%b carry=%b, required state=2 loads=%b carry=%0d", ins, state, {load_a, load_b, load_out}, carry, exp_ld, c_m); end
      if (exp_ld != 3'b000) begin
         vecs++;
         if (dat_wr !== 4'(d))
            begin errs++; $display("FAIL dat_wr ins=%h: got %h, required %h", ins, dat_wr, 4'(d)); end
      end
      @(negedge clk_cpu);
      vecs++;
      if (state !== 2'd0 || rom_addr !== 4'(npc) || carry !== 1'(nc) || {load_a, load_b, load_out} !== 3'b000)
         begin errs++; $display("FAIL retire ins=%h: state=%0d pc=%0d carry=%b loads=%b, required state=0 pc=%0d carry=%0d loads=000", ins, state, rom_addr, carry, {load_a, load_b, load_out}, npc, nc); end
      if (exp_ld[2]) a_m = d;
      if (exp_ld[1]) b_m = d;
      if (exp_ld[0]) o_m = d;
      pc_m = npc;
      c_m  = nc;
      vecs++;
      if ({ra, rb, ro} !== {4'(a_m), 4'(b_m), 4'(o_m)})
         begin errs++; $display("FAIL regs ins=%h: A=%h B=%h OUT=%h, required A=%h B=%h OUT=%h", ins, ra, rb, ro, 4'(a_m), 4'(b_m), 4'(o_m)); end
   endtask

   task automatic idle_check(input int n);
      run  = 1'b0;
      step = 1'b0;
      repeat (n) begin
         @(negedge clk_cpu);
         vecs++;
         if (state !== 2'd0 || rom_addr !== 4'(pc_m) || {load_a, load_b, load_out} !== 3'b000)
            begin errs++; $display("FAIL idle: state=%0d pc=%0d loads=%b, required state=0 pc=%0d loads=000", state, rom_addr, {load_a, load_b, load_out}, pc_m); end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk_cpu);
      vecs++;
      if (state !== 2'd0 || rom_addr !== 4'd0 || carry !== 1'b0 || dat_wr !== 4'd0 ||
          {load_a, load_b, load_out} !== 3'b000)
         begin errs++; $display("FAIL reset: state=%0d pc=%0d carry=%b dat_wr=%h loads=%b, required all zero", state, rom_addr, carry, dat_wr, {load_a, load_b, load_out}); end
      do_reset();
   endtask

   task automatic test_program();
      do_reset();
      rom[0] = 8'h35; rom[1] = 8'h3E; rom[2] = 8'h03;
      rom[3] = 8'hE7; rom[4] = 8'hE9; rom[9] = 8'hF0;
      exec_one(1'b0);
      vecs++;
      if (ra !== 4'd5 || rom_addr !== 4'd1)
         begin errs++; $display("FAIL mov_a: A=%h pc=%0d, required A=5 pc=1", ra, rom_addr); end
      exec_one(1'b0);
      exec_one(1'b0);
      vecs++;
      if (ra !== 4'h1 || carry !== 1'b1)
         begin errs++; $display("FAIL add_carry: A=%h carry=%b, required A=1 carry=1", ra, carry); end
      exec_one(1'b0);
      vecs++;
      if (rom_addr !== 4'd4 || carry !== 1'b0)
         begin errs++; $display("FAIL jnc_not_taken: pc=%0d carry=%b, required pc=4 carry=0", rom_addr, carry); end
      exec_one(1'b0);
      vecs++;
      if (rom_addr !== 4'd9)
         begin errs++; $display("FAIL jnc_taken: pc=%0d, required 9", rom_addr); end
      exec_one(1'b0);
      vecs++;
      if (rom_addr !== 4'd0)
         begin errs++; $display("FAIL jmp: pc=%0d, required 0", rom_addr); end
      idle_check(1);
   endtask

   task automatic test_wrap();
      do_reset();
      rom[0] = 8'h3F; rom[1] = 8'hFE; rom[14] = 8'h01; rom[15] = 8'h80;
      repeat (3) exec_one(1'b0);
      vecs++;
      if (carry !== 1'b1 || rom_addr !== 4'hF)
         begin errs++; $display("FAIL wrap_setup: carry=%b pc=%0d, required carry=1 pc=15", carry, rom_addr); end
      exec_one(1'b0);
      vecs++;
      if (carry !== 1'b0 || rom_addr !== 4'h0)
         begin errs++; $display("FAIL wrap: carry=%b pc=%0d, required carry=0 pc=0", carry, rom_addr); end
      idle_check(1);
   endtask

   task automatic test_step();
      do_reset();
      rom[0] = 8'hB6;
      idle_check(3);
      exec_one(1'b1);
      vecs++;
      if (ro !== 4'd6)
         begin errs++; $display("FAIL step_out: OUT=%h, required 6", ro); end
      idle_check(12);
   endtask

   task automatic test_reset_mid();
      do_reset();
      rom[0] = 8'h3E; rom[1] = 8'h03;
      exec_one(1'b0);
      @(negedge clk_cpu);
      @(negedge clk_cpu);
      vecs++;
      if (state !== 2'd2 || load_a !== 1'b1 || dat_wr !== 4'h1)
         begin errs++; $display("FAIL pre_reset_exec: state=%0d load_a=%b dat_wr=%h, required 2 1 1", state, load_a, dat_wr); end
      reset = 1'b1;
      run   = 1'b0;
      @(negedge clk_cpu);
      vecs++;
      if (state !== 2'd0 || rom_addr !== 4'd0 || carry !== 1'b0 || dat_wr !== 4'd0 ||
          {load_a, load_b, load_out} !== 3'b000)
         begin errs++; $display("FAIL reset_mid: state=%0d pc=%0d carry=%b dat_wr=%h loads=%b, required all zero", state, rom_addr, carry, dat_wr, {load_a, load_b, load_out}); end
      reset = 1'b0;
      pc_m = 0; c_m = 0; a_m = 0; b_m = 0; o_m = 0;
      idle_check(2);
   endtask

   task automatic test_random();
      bit use_step;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         if (i % 24 == 0)
            for (int k = 0; k < 16; k++) rom[k] = 8'($urandom);
         use_step = ($urandom_range(0, 3) == 0);
         if (use_step) idle_check($urandom_range(0, 3));
         exec_one(use_step);
      end
      idle_check(2);
   endtask

   initial begin
      for (int k = 0; k < 16; k++) rom[k] = 8'h80;
      test_reset();
      test_program();
      test_wrap();
      test_step();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Instruction sequencer for the 4-bit CPU. It fetches 8-bit instructions from program ROM and decodes them. It drives the load strobes and write data of the A, B and OUT register_file instances, and it owns the PC and the carry flag. It sits between the ROM and the register files, and it also holds the 4-bit adder used for ADD.

Parameters:
PC_RESET, 4'd0, PC value loaded on reset

Ports:
clk_cpu  input  1  CPU clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  level; 1 = execute instructions continuously
step  input  1  pulse; while run=0, a high sample in FETCH executes exactly one instruction
rom_addr  output  4  program ROM address; equals PC
rom_data  input  8  instruction at rom_addr; [7:4] opcode, [3:0] immediate
reg_a  input  4  current dat_out of register A
reg_b  input  4  current dat_out of register B
in_port  input  4  external input switches
load_a  output  1  load strobe for register A
load_b  output  1  load strobe for register B
load_out  output  1  load strobe for OUT register
dat_wr  output  4  write data, shared by all three register loads
carry  output  1  carry flag
state  output  2  FSM state: 0=FETCH, 1=DECODE, 2=EXEC

Behaviour:
- Reset (synchronous, highest priority, overrides any state including mid-instruction):
  - pc=PC_RESET, ir=8'h00, carry=0, dat_wr=0.
  - load_a, load_b and load_out = 0; state=FETCH.
- FSM: FETCH -> DECODE -> EXEC -> FETCH. Each instruction takes exactly 3 cycles.
- FETCH:
  - rom_addr=pc, combinational from the pc register.
  - If run=1, or (run=0 and step=1): ir <= rom_data and go to DECODE.
  - Otherwise hold in FETCH; no state changes.
- DECODE:
  - Compute dat_wr and the target from ir into registers; all strobes stay 0.
  - run/step are ignored in this state and in EXEC.
- EXEC:
  - Exactly one (or zero) of load_a, load_b and load_out is 1, for this single cycle only.
  - dat_wr is held stable for the whole cycle.
  - pc <= next_pc and carry <= new_carry; then go to FETCH.
- Strobes and dat_wr are registered outputs. The register files capture at the rising edge that ends EXEC.
- Opcodes (im = ir[3:0]; arithmetic is 4-bit, and the carry-out goes to carry):
  - 0000 ADD A,im: dat_wr=reg_a+im, load_a, carry=carry-out.
  - 0101 ADD B,im: dat_wr=reg_b+im, load_b, carry=carry-out.
  - 0011 MOV A,im: dat_wr=im, load_a.
  - 0111 MOV B,im: dat_wr=im, load_b.
  - 0001 MOV A,B: dat_wr=reg_b, load_a.
  - 0100 MOV B,A: dat_wr=reg_a, load_b.
  - 0010 IN A: dat_wr=in_port, load_a.
  - 0110 IN B: dat_wr=in_port, load_b.
  - 1001 OUT B: dat_wr=reg_b, load_out.
  - 1011 OUT im: dat_wr=im, load_out.
  - 1111 JMP im: next_pc=im, no load.
  - 1110 JNC im: next_pc = im if carry==0 (the value before this instruction), else pc+1; no load.
  - All other opcodes are NOP: no load, next_pc=pc+1.
- Carry rule: ADD sets carry to its carry-out. Every other executed instruction, including NOP, JMP and JNC, clears carry to 0.
- PC: next_pc=pc+1 modulo 16 unless a jump is taken. 4'hF+1 wraps to 4'h0.
- Operand sampling: reg_a, reg_b and in_port are sampled in DECODE. Changes during EXEC do not affect dat_wr.
- step while run=1 has no extra effect. step held high with run=0 executes one instruction per 3 cycles; this is not edge-detected here.
- run deasserted mid-instruction: the current instruction completes, then the FSM holds in FETCH.

Test Plan:
- Reset then run=1, ROM[0]=8'h35 (MOV A,5) -> load_a=1 for 1 cycle in cycle 3, dat_wr=5, pc 0->1, carry=0.
- A=4'hE, ROM[1]=8'h03 (ADD A,3) -> dat_wr=4'h1, load_a=1, carry=1. Then ROM[2]=8'hE7 (JNC 7) -> pc=3 (no jump), carry=0.
- ROM[3]=8'hE9 with carry=0 -> pc=9. ROM[9]=8'hF0 (JMP 0) -> pc=0, no strobes asserted.
- ROM[15]=8'h80 (NOP), run=1 -> pc wraps 4'hF->4'h0, carry cleared, all strobes 0.
- run=0, step pulsed once, ROM[0]=8'hB6 (OUT 6) -> load_out=1 once, dat_wr=6, FSM then idles in FETCH with pc=1 for 10+ cycles.
- reset asserted in EXEC of ADD -> next cycle: state=FETCH, pc=0, carry=0, all strobes 0, no register load.
